// File: rtl/nn_pkg.sv
// nn_pkg: FP32 field layout, special constants, FSM states and sizing helpers shared by the inference engine.
package nn_pkg;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_ONE = 32'h3F800000;
  typedef enum logic [2:0] {S_LOAD, S_BIAS, S_MAC, S_WRITE, S_OUT} state_t;
  function automatic int aw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic fp_zero(input logic [31:0] v);
    return v[30:FP_MAN_W] == '0;
  endfunction
  function automatic logic fp_inf(input logic [31:0] v);
    return &v[30:FP_MAN_W] && v[FP_MAN_W-1:0] == '0;
  endfunction
  function automatic logic fp_nan(input logic [31:0] v);
    return &v[30:FP_MAN_W] && v[FP_MAN_W-1:0] != '0;
  endfunction
endpackage

// File: rtl/fp32_mul_add.sv
// fp32_mul_add: y = c + a*b, multiply and add each truncated toward zero, subnormals flushed to +0.
module fp32_mul_add
  import nn_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic [31:0] y
);
  logic [47:0] pm;
  logic signed [9:0] pe, se;
  logic [31:0] p, cc, big, sml;
  logic [FP_EXP_W-1:0] d;
  logic [50:0] bm, sm, s, sh;
  logic [5:0] msb;
  logic unused_bits;
  assign unused_bits = ^{pm[22:0], sh[50], sh[26:0], pe[9:8], se[9:8]};
  always_comb begin
    pm = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    pe = $signed({2'b0, a[30:23]}) + $signed({2'b0, b[30:23]}) - 10'sd127 + (pm[47] ? 10'sd1 : 10'sd0);
    p = (fp_nan(a) || fp_nan(b) || (fp_inf(a) && fp_zero(b)) || (fp_zero(a) && fp_inf(b))) ? FP_QNAN
      : (fp_inf(a) || fp_inf(b)) ? {a[31] ^ b[31], 8'hFF, 23'd0}
      : (fp_zero(a) || fp_zero(b) || pe <= 10'sd0) ? 32'd0
      : pe >= 10'sd255 ? {a[31] ^ b[31], 8'hFF, 23'd0}
      : {a[31] ^ b[31], pe[7:0], pm[47] ? pm[46:24] : pm[45:23]};
    cc = fp_zero(c) ? 32'd0 : c;
    big = cc[30:0] > p[30:0] ? cc : p;
    sml = cc[30:0] > p[30:0] ? p : cc;
    d = big[30:23] - sml[30:23];
    // 26 guard bits keep alignment exact; beyond that the small operand only acts as a sticky bit
    bm = {2'b01, big[22:0], 26'd0};
    sm = d > 8'd26 ? 51'd1 : {2'b01, sml[22:0], 26'd0} >> d;
    s = big[31] == sml[31] ? bm + sm : bm - sm;
    msb = '0;
    for (int i = 0; i < 51; i++) if (s[i]) msb = 6'(i);
    sh = s << (6'd50 - msb);
    se = $signed({2'b0, big[30:23]}) + $signed({4'b0, msb}) - 10'sd49;
    y = (fp_nan(p) || fp_nan(cc) || (fp_inf(p) && fp_inf(cc) && p[31] != cc[31])) ? FP_QNAN
      : fp_inf(p) ? p
      : fp_inf(cc) ? cc
      : fp_zero(p) ? cc
      : fp_zero(cc) ? p
      : (s == '0 || se <= 10'sd0) ? 32'd0
      : se >= 10'sd255 ? {big[31], 8'hFF, 23'd0}
      : {big[31], se[7:0], sh[49:27]};
  end
endmodule

// File: rtl/neural_network_new.sv
// neural_network_new: serial FP32 dense-layer inference engine with one shared multiply-add.
module neural_network_new
  import nn_pkg::*;
#(
  parameter int NR_LAYERS = 2,
  parameter int INPUTSIZE = 4,
  parameter int OUTPUTSIZE = 10,
  parameter int MAXWEIGHTS = 4,
  parameter int MAXRESULTS = 10,
  parameter string WEIGHT_FILE = "weights.hex",
  parameter string BIAS_FILE = "biases.hex"
) (
  input  logic clk,
  input  logic rst,
  input  logic [32*INPUTSIZE-1:0] inputdata,
  input  logic [32*NR_LAYERS-1:0] neuron_count,
  output logic [32*OUTPUTSIZE-1:0] result,
  output logic valid
);
  localparam int NW = NR_LAYERS * MAXRESULTS * MAXWEIGHTS;
  localparam int NB = NR_LAYERS * MAXRESULTS;
  localparam int WAW = aw(NW);
  localparam int BAW = aw(NB);
  localparam int RW = aw(MAXRESULTS);
  localparam int LW = aw(NR_LAYERS);
  localparam int CW = aw(MAXRESULTS + MAXWEIGHTS + 1);
  logic [31:0] wrom [NW];
  logic [31:0] brom [NB];
  logic [31:0] lbuf [2][MAXRESULTS];
  logic [CW-1:0] cnt [NR_LAYERS];
  logic [CW-1:0] neuron, k, n_in, prev_cnt;
  logic [LW-1:0] layer;
  logic sel, last_n, last_l;
  logic [31:0] acc, mac, act, src, wgt;
  state_t state, nxt;
  function automatic logic [CW-1:0] sanitize(input logic [31:0] v);
    return v == 32'd0 ? CW'(1) : v > 32'(MAXRESULTS) ? CW'(MAXRESULTS) : CW'(v);
  endfunction
  fp32_mul_add u_mac (.a(src), .b(wgt), .c(acc), .y(mac));
  always_comb begin
    prev_cnt = layer == '0 ? CW'(INPUTSIZE) : cnt[layer - 1'b1];
    n_in = prev_cnt > CW'(MAXWEIGHTS) ? CW'(MAXWEIGHTS) : prev_cnt;
    last_n = neuron == cnt[layer] - 1'b1;
    last_l = layer == LW'(NR_LAYERS - 1);
    src = lbuf[sel][RW'(k)];
    wgt = wrom[WAW'((int'(layer) * MAXRESULTS + int'(neuron)) * MAXWEIGHTS + int'(k))];
`ifdef NN_RELU_EN
    act = (!last_l && acc[31]) ? 32'd0 : acc;
`else
    act = acc;
`endif
    nxt = state == S_LOAD ? S_BIAS
        : state == S_BIAS ? S_MAC
        : state == S_MAC ? (k == n_in - 1'b1 ? S_WRITE : S_MAC)
        : state == S_WRITE ? (last_n && last_l ? S_OUT : S_BIAS)
        : S_LOAD;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_LOAD;
      layer <= '0;
      neuron <= '0;
      k <= '0;
      sel <= 1'b0;
      acc <= '0;
      result <= '0;
      valid <= 1'b0;
      for (int l = 0; l < NR_LAYERS; l++) cnt[l] <= '0;
      for (int i = 0; i < MAXRESULTS; i++) begin
        lbuf[0][i] <= '0;
        lbuf[1][i] <= '0;
      end
    end else begin
      state <= nxt;
      valid <= state == S_OUT;
      case (state)
        S_LOAD: begin
          for (int i = 0; i < INPUTSIZE; i++) lbuf[0][RW'(i)] <= inputdata[32*i +: 32];
          for (int l = 0; l < NR_LAYERS; l++) cnt[l] <= sanitize(neuron_count[32*l +: 32]);
          layer <= '0;
          neuron <= '0;
          sel <= 1'b0;
        end
        S_BIAS: begin
          acc <= brom[BAW'(int'(layer) * MAXRESULTS + int'(neuron))];
          k <= '0;
        end
        S_MAC: begin
          acc <= mac;
          k <= k + 1'b1;
        end
        S_WRITE: begin
          lbuf[~sel][RW'(neuron)] <= act;
          neuron <= last_n ? '0 : neuron + 1'b1;
          if (last_n && !last_l) begin
            sel <= ~sel;
            layer <= layer + 1'b1;
          end
        end
        S_OUT:
          for (int j = 0; j < OUTPUTSIZE; j++)
            result[32*j +: 32] <= (j < MAXRESULTS && j < int'(cnt[NR_LAYERS-1])) ? lbuf[~sel][RW'(j % MAXRESULTS)] : 32'd0;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_neural_network_new.sv
// tb_neural_network_new: directed vectors for the FP32 inference engine with ROMs preloaded from the bench.
module tb_neural_network_new;
  import nn_pkg::*;
  localparam logic [31:0] TEN = 32'h41200000;
`ifdef NN_RELU_EN
  localparam logic [31:0] NEG_EXP = 32'h00000000;
`else
  localparam logic [31:0] NEG_EXP = 32'hC2F00000;
`endif
  typedef struct {
    logic [31:0] w0, w1, b, x, c0, c1, exp;
    int nz, len;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [127:0] inputdata;
  logic [63:0] neuron_count;
  logic [319:0] result;
  logic valid;
  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs [12];

  neural_network_new #(.WEIGHT_FILE(""), .BIAS_FILE("")) dut (
    .clk(clk), .rst(rst), .inputdata(inputdata), .neuron_count(neuron_count),
    .result(result), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setup(input logic [31:0] w0, w1, b, x, c0, c1);
    for (int i = 0; i < 80; i++) dut.wrom[7'(i)] = i < 40 ? w0 : w1;
    for (int i = 0; i < 20; i++) dut.brom[5'(i)] = b;
    inputdata = {4{x}};
    neuron_count = {c1, c0};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result_nonzero", {31'd0, |result}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int exp_len);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!valid && n < 300);
    check(name, 32'(n), 32'(exp_len));
  endtask

  task automatic check_result(input string name, input logic [31:0] exp, input int nz);
    for (int j = 0; j < 10; j++)
      check($sformatf("%s_res%0d", name, j), result[32*j +: 32], j < nz ? exp : 32'd0);
  endtask

  initial begin
    inputdata = '0;
    neuron_count = '0;
    vecs[0]  = '{FP_ONE, FP_ONE, 32'h0, TEN, 32'd3, 32'd10, 32'h42F00000, 10, 70};
    vecs[1]  = '{FP_ONE, FP_ONE, 32'h3F000000, TEN, 32'd3, 32'd10, 32'h42F40000, 10, 70};
    vecs[2]  = '{32'hBF800000, FP_ONE, 32'h0, TEN, 32'd3, 32'd10, NEG_EXP, 10, 70};
    vecs[3]  = '{FP_ONE, FP_ONE, 32'h0, FP_ONE, 32'd3, 32'd10, 32'h41400000, 10, 70};
    vecs[4]  = '{FP_ONE, FP_ONE, 32'h0, TEN, 32'd3, 32'd0, 32'h42F00000, 1, 25};
    vecs[5]  = '{32'h40000000, 32'h40000000, 32'h0, 32'h3FC00000, 32'd3, 32'd10, 32'h42900000, 10, 70};
    vecs[6]  = '{32'h7F000000, 32'h7F000000, 32'h0, FP_ONE, 32'd3, 32'd10, 32'h7F800000, 10, 70};
    vecs[7]  = '{FP_ONE, FP_ONE, 32'h0, FP_QNAN, 32'd3, 32'd10, FP_QNAN, 10, 70};
    vecs[8]  = '{FP_ONE, FP_ONE, 32'hC2200000, TEN, 32'd3, 32'd10, 32'hC2200000, 10, 70};
    vecs[9]  = '{FP_ONE, FP_ONE, 32'h4B800000, 32'h40400000, 32'd3, 32'd10, 32'h4C800003, 10, 70};
    vecs[10] = '{FP_ONE, FP_ONE, 32'h0, TEN, 32'd3, 32'd99, 32'h42F00000, 10, 70};
    vecs[11] = '{FP_ONE, FP_ONE, 32'h0, TEN, 32'd0, 32'd10, 32'h42200000, 10, 38};
    for (int v = 0; v < 12; v++) begin
      setup(vecs[v].w0, vecs[v].w1, vecs[v].b, vecs[v].x, vecs[v].c0, vecs[v].c1);
      do_reset();
      wait_valid($sformatf("v%0d_len", v), vecs[v].len);
      check_result($sformatf("v%0d", v), vecs[v].exp, vecs[v].nz);
    end
    // input change mid-pass only affects the following pass
    setup(FP_ONE, FP_ONE, 32'h0, TEN, 32'd3, 32'd10);
    do_reset();
    repeat (29) @(posedge clk);
    #1 inputdata = {4{FP_ONE}};
    wait_valid("seqA_len1", 41);
    check_result("seqA_p1", 32'h42F00000, 10);
    @(posedge clk);
    #1;
    check("seqA_valid_pulse", {31'd0, valid}, 32'd0);
    check("seqA_hold", result[32*9 +: 32], 32'h42F00000);
    wait_valid("seqA_len2", 69);
    check_result("seqA_p2", 32'h41400000, 10);
    // asynchronous reset in the middle of a pass
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("seqB_async_clear", {31'd0, |result}, 32'd0);
    check("seqB_async_valid", {31'd0, valid}, 32'd0);
    inputdata = {4{TEN}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_valid("seqB_len", 70);
    check_result("seqB", 32'h42F00000, 10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
